// File: rtl/line_encoder_fifo.sv
// Rising-edge detector on four one-hot decode lines. Each event is encoded back
// to its 2-bit select code {A,B} and queued in a small FIFO drained by valid/ready.
module line_encoder_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       F1,
    input  logic                       F2,
    input  logic                       F3,
    input  logic                       F4,
    input  logic                       clr_flags,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [1:0]                 out_code,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       multi_err,
    output logic                       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    r_in_q;
    logic [3:0]    r_prev_q;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_multi_err;
    logic          r_overflow;
    logic [1:0]    r_mem [DEPTH];

    logic [3:0]    w_rise;
    logic [1:0]    w_code;
    logic          w_multi;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_write;
    logic          w_drop;

    // Bit 3 is F1 (code 11) down to bit 0 = F4 (code 00).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            assign w_rise[gi] = r_in_q[gi] & ~r_prev_q[gi];
        end
    endgenerate

    always_comb begin
        w_code = 2'b00;
        if (w_rise[3])      w_code = 2'b11;
        else if (w_rise[2]) w_code = 2'b10;
        else if (w_rise[1]) w_code = 2'b01;
        else                w_code = 2'b00;
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multi = |(w_rise & (w_rise - 4'd1));
    assign w_push  = |w_rise;
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & out_ready;
    // When full, a simultaneous pop frees the slot at rd_ptr == wr_ptr.
    assign w_write = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q      <= '0;
            r_prev_q    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_multi_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_in_q   <= {F1, F2, F3, F4};
            r_prev_q <= r_in_q;

            if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);

            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_multi)        r_multi_err <= 1'b1;
            else if (clr_flags) r_multi_err <= 1'b0;

            if (w_drop)         r_overflow <= 1'b1;
            else if (clr_flags) r_overflow <= 1'b0;
        end
    end

    assign out_valid = ~w_empty;
    assign out_code  = w_empty ? 2'b00 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign multi_err = r_multi_err;
    assign overflow  = r_overflow;

endmodule

// File: doc/line_encoder_fifo.md
# line_encoder_fifo

Sequential inverse of the team's 4-line PLA decoder. Watches four one-hot decode lines F1..F4 and detects rising edges. Each detected event is encoded back into the 2-bit select code {A,B} that would drive that line, and the code is queued in a small FIFO. The FIFO is drained through a valid/ready handshake. The block sits on the return path of a decoded select bus and turns line strobes into a code stream for a downstream consumer.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2 to 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock domain.
- F1  input  1  decode line for {A,B}=11.
- F2  input  1  decode line for {A,B}=10.
- F3  input  1  decode line for {A,B}=01.
- F4  input  1  decode line for {A,B}=00.
- clr_flags  input  1  synchronous clear of the sticky error flags.
- out_ready  input  1  consumer accepts the head entry.
- out_valid  output  1  FIFO not empty.
- out_code  output  2  head entry {A,B}; out_code[1]=A, out_code[0]=B.
- count  output  $clog2(DEPTH+1)  number of entries held.
- multi_err  output  1  sticky: two or more lines rose in the same cycle.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Sampling:
  - Stage register in_q <= {F1,F2,F3,F4} on every clock.
  - Second register prev_q <= in_q.
  - rise = in_q & ~prev_q is a combinational, per-line edge detect.
- Encoding: F1->2'b11, F2->2'b10, F3->2'b01, F4->2'b00.
- Priority: if more than one bit of rise is set, only the highest-priority line is encoded (F1 > F2 > F3 > F4). multi_err is set on the next edge.
- Push: push = |rise. Pop: pop = out_valid & out_ready.
- FIFO behaviour:
  - Circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits.
  - Both pointers wrap from DEPTH-1 to 0.
  - count is tracked explicitly, so full and empty are unambiguous.
  - Full is count==DEPTH. Empty is count==0.
- push, not full: write the code at wr_ptr, increment wr_ptr and count.
- push while full, no pop: drop the event. Pointers and count are unchanged. Set overflow.
- push while full, with pop: both push and pop take effect. count stays DEPTH. No overflow.
- push and pop while not full and not empty: both take effect. count is unchanged.
- pop while empty cannot occur, because out_valid is 0.
- out_code is the entry at rd_ptr. It is held stable while out_valid=1 and out_ready=0.
- There is no bypass. An event pushed into an empty FIFO appears on the following cycle.
- Sticky flags:
  - Set by their events.
  - Cleared by clr_flags=1.
  - If a set event and clr_flags occur in the same cycle, set wins.
- Lines held high produce no further events. A line must fall, then rise again, to produce another event.

## Timing
- Reset (asynchronous assert, any time, including mid-transfer) forces:
  - in_q=0, prev_q=0, wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_code=2'b00, multi_err=0, overflow=0.
  - FIFO contents are discarded.
- Reset release: a line already high at the first clock after release produces one event, because prev_q=0.
- Latency from the input to the output:
  - A line goes high before edge k.
  - in_q captures it at edge k.
  - The push happens at edge k+1.
  - out_valid=1 (if the FIFO was empty) and count increments after edge k+1.
  - Total: 2 cycles.
- Throughput: one push and one pop per cycle.
- Minimum pulse: a pulse high for one full cycle, covering at least one sampling edge, is captured. Shorter pulses may be missed.
- Handshake: a transfer occurs on an edge with out_valid=1 and out_ready=1. The next entry, if any, is presented after that edge.
- Flag timing: multi_err and overflow assert one cycle after the offending push cycle, the same edge as the push.

## Test plan
- Reset then single events:
  - Stimulus: pulse F3 high for one cycle, out_ready=1.
  - Response: out_valid=1 with out_code=2'b01 exactly 2 cycles after the pulse, for 1 cycle; count returns to 0.
- Encoding sweep:
  - Stimulus: out_ready=0; pulse F1, F2, F3, F4 in separate cycles; then raise out_ready.
  - Response: count=4, then codes 11, 10, 01, 00 in order. multi_err=0.
- Simultaneous lines:
  - Stimulus: F2 and F4 rise in the same cycle.
  - Response: exactly one entry, code 2'b10. multi_err=1 stays set until clr_flags. With clr_flags and a new multi-rise in the same cycle, multi_err stays 1.
- Overflow and wrap:
  - Stimulus: DEPTH=4, out_ready=0, five separate F1 pulses.
  - Response: count=4 and overflow=1. Draining yields 4 entries.
  - Follow-up: repeat the fill/drain 3 times. Codes stay correct across pointer wrap.
- Full with simultaneous pop:
  - Stimulus: with count=4 and out_ready=1, a new rise arrives.
  - Response: count stays 4, overflow stays 0, and the new code appears last in order.
- Held line and mid-operation reset:
  - Stimulus: hold F4 high for 10 cycles. Separately, with count=3, assert rst_n=0 for 1 cycle.
  - Response: the held line gives one event. After reset, out_valid=0, count=0, flags=0. A line still high at release gives one event.
